// File: rtl/wash_cycle_ctrl_if.sv
// Bundle of the operator controls and display/status outputs of wash_cycle_ctrl.
// The master side is the operator panel (drives start/on).
// The slave side is the controller (drives the display and status signals).
interface wash_cycle_ctrl_if;
  logic       start;
  logic       on;
  logic [3:0] dig3;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [7:0] st_light;
  logic [2:0] phase;
  logic       done;

  modport master (
    output start, on,
    input  dig3, dig2, dig1, dig0, st_light, phase, done
  );

  modport slave (
    input  start, on,
    output dig3, dig2, dig1, dig0, st_light, phase, done
  );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine program controller.
// Runs the phases IDLE -> FILL -> WASH -> [RINSE] -> SPIN -> DONE on a divided 1 s tick.
// It counts the remaining program seconds down and ramps the water level.
// It drives the BCD digits of the scan4 display and the status LED bar.
// Optional feature: define WASH_RINSE_EN to include the RINSE phase and its seconds.
module wash_cycle_ctrl #(
  parameter int         TICK_DIV  = 100000000,
  parameter int         FILL_S    = 9,
  parameter int         WASH_S    = 40,
  parameter int         RINSE_S   = 20,
  parameter int         SPIN_S    = 9,
  parameter int         LEVEL_MAX = 9,
  parameter logic [3:0] BLANK     = 4'd11
) (
  input logic              clk,
  input logic              rst,
  wash_cycle_ctrl_if.slave bus
);

`ifdef WASH_RINSE_EN
  localparam int RINSE_PART = RINSE_S;
`else
  localparam int RINSE_PART = 0;
`endif
  localparam int TOTAL = FILL_S + WASH_S + RINSE_PART + SPIN_S;
  localparam int TCW   = $clog2(TICK_DIV);

  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [6:0]     TOTAL_V   = 7'(TOTAL);
  localparam logic [3:0]     LEVEL_TOP = 4'(LEVEL_MAX);

  // Reject parameter sets the two-digit display or the counters cannot represent.
  generate
    if (TOTAL > 99) begin : g_total_err
      $error("wash_cycle_ctrl: program total exceeds 99 seconds");
    end
    if (TICK_DIV < 2) begin : g_div_err
      $error("wash_cycle_ctrl: TICK_DIV must be at least 2");
    end
    if (FILL_S < 1 || WASH_S < 1 || RINSE_S < 1 || SPIN_S < 1) begin : g_dur_err
      $error("wash_cycle_ctrl: every phase must last at least 1 second");
    end
    if (LEVEL_MAX < 1 || LEVEL_MAX > 9) begin : g_lvl_err
      $error("wash_cycle_ctrl: LEVEL_MAX must be within 1..9");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
`ifdef WASH_RINSE_EN
    RINSE = 3'd3,
`endif
    SPIN  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [6:0]     rem;
  logic [6:0]     phase_cnt;
  logic [6:0]     next_dur;
  logic [3:0]     level;
  logic [TCW-1:0] tick_cnt;
  logic           running;
  logic           launch;
  logic           tick;
  logic           phase_end;

  assign running   = (state != IDLE) && (state != DONE);
  assign launch    = !running && bus.start;
  assign tick      = running && bus.on && (tick_cnt == TICK_LAST);
  assign phase_end = tick && (phase_cnt == 7'd1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic and the duration loaded into phase_cnt on a phase change.
  always_comb begin
    // NOTE: defaults first so that no path through the case leaves a signal
    // unassigned, which would infer a latch.
    next_state = state;
    next_dur   = '0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) next_state = FILL;
      end
      FILL: begin
        if (phase_end) begin
          next_state = WASH;
          next_dur   = 7'(WASH_S);
        end
      end
      WASH: begin
        if (phase_end) begin
`ifdef WASH_RINSE_EN
          next_state = RINSE;
          next_dur   = 7'(RINSE_S);
`else
          next_state = SPIN;
          next_dur   = 7'(SPIN_S);
`endif
        end
      end
`ifdef WASH_RINSE_EN
      RINSE: begin
        if (phase_end) begin
          next_state = SPIN;
          next_dur   = 7'(SPIN_S);
        end
      end
`endif
      SPIN: begin
        if (phase_end) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Program datapath: second divider, remaining time, phase countdown and water level.
  // Everything holds while paused, so a partial second survives a pause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem       <= TOTAL_V;
      phase_cnt <= '0;
      level     <= '0;
      tick_cnt  <= '0;
    end else if (launch) begin
      rem       <= TOTAL_V;
      phase_cnt <= 7'(FILL_S);
      level     <= '0;
      tick_cnt  <= '0;
    end else if (running && bus.on) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        if (rem != 7'd0) rem <= rem - 7'd1;
        phase_cnt <= phase_end ? next_dur : phase_cnt - 7'd1;
        if (state == FILL && level < LEVEL_TOP)  level <= level + 4'd1;
        else if (state == SPIN && level != 4'd0) level <= level - 4'd1;
      end
    end
  end

  // Status LED bar decoded from the state register.
  always_comb begin
    bus.st_light = 8'h00;
    case (state)
      FILL:    bus.st_light = 8'h0F;
      WASH:    bus.st_light = 8'h3F;
`ifdef WASH_RINSE_EN
      RINSE:   bus.st_light = 8'h7F;
`endif
      SPIN:    bus.st_light = 8'hFF;
      DONE:    bus.st_light = 8'hAA;
      default: bus.st_light = 8'h00;
    endcase
  end

  assign bus.phase = state;
  assign bus.done  = (state == DONE);
  assign bus.dig3  = level;
  assign bus.dig2  = BLANK;
  assign bus.dig1  = 4'(rem / 7'd10);
  assign bus.dig0  = 4'(rem % 7'd10);

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl with TICK_DIV=4, FILL_S=3, WASH_S=4,
// RINSE_S=2, SPIN_S=3, LEVEL_MAX=9. Expected values are hand-computed.
// They follow WASH_RINSE_EN when the macro is defined for the build.
`timescale 1ns/1ps
module tb_wash_cycle_ctrl;

`ifdef WASH_RINSE_EN
  localparam int T         = 12;  // 3+4+2+3
  localparam int RINSE_EXP = 1;
`else
  localparam int T         = 10;  // 3+4+3
  localparam int RINSE_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   seen_rinse = 0;

  wash_cycle_ctrl_if wif ();

  wash_cycle_ctrl #(
    .TICK_DIV (4),
    .FILL_S   (3),
    .WASH_S   (4),
    .RINSE_S  (2),
    .SPIN_S   (3),
    .LEVEL_MAX(9)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(wif)
  );

  always #5 clk = ~clk;

  // Watch for the RINSE encoding at every mid-cycle point.
  always @(negedge clk) if (wif.phase == 3'd3) seen_rinse = 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_rem(input string tag, input int exp);
    check({tag, "_tens"}, wif.dig1, exp / 10);
    check({tag, "_ones"}, wif.dig0, exp % 10);
  endtask

  // Count consecutive post-edge samples spent in phase ph, bounded.
  task automatic measure(input string tag, input int ph, input int exp_len);
    int n;
    n = 0;
    while (wif.phase == 3'(ph) && n < 500) begin
      n++;
      step(1);
    end
    check({tag, "_len"}, n, exp_len);
  endtask

  task automatic wait_phase(input string tag, input int ph);
    int n;
    n = 0;
    while (wif.phase != 3'(ph) && n < 200) begin
      n++;
      step(1);
    end
    check(tag, wif.phase, ph);
  endtask

  // Launch from IDLE/DONE and walk the whole program, checking every boundary.
  task automatic run_program(input string tag, input bit hold_start);
    wif.start = 1'b1;
    step(1);
    if (!hold_start) wif.start = 1'b0;
    check({tag, "_fill_phase"}, wif.phase, 1);
    check({tag, "_fill_led"}, wif.st_light, 8'h0F);
    check({tag, "_fill_done"}, wif.done, 0);
    check({tag, "_fill_lvl"}, wif.dig3, 0);
    check_rem({tag, "_fill_rem"}, T);
    measure({tag, "_fill"}, 1, 12);
    check({tag, "_wash_phase"}, wif.phase, 2);
    check({tag, "_wash_led"}, wif.st_light, 8'h3F);
    check({tag, "_wash_lvl"}, wif.dig3, 3);
    check_rem({tag, "_wash_rem"}, T - 3);
    measure({tag, "_wash"}, 2, 16);
`ifdef WASH_RINSE_EN
    check({tag, "_rinse_phase"}, wif.phase, 3);
    check({tag, "_rinse_led"}, wif.st_light, 8'h7F);
    check({tag, "_rinse_lvl"}, wif.dig3, 3);
    check_rem({tag, "_rinse_rem"}, T - 7);
    measure({tag, "_rinse"}, 3, 8);
`endif
    check({tag, "_spin_phase"}, wif.phase, 4);
    check({tag, "_spin_led"}, wif.st_light, 8'hFF);
    check({tag, "_spin_lvl"}, wif.dig3, 3);
    check_rem({tag, "_spin_rem"}, 3);
    measure({tag, "_spin"}, 4, 12);
    check({tag, "_done_phase"}, wif.phase, 5);
    check({tag, "_done_flag"}, wif.done, 1);
    check({tag, "_done_led"}, wif.st_light, 8'hAA);
    check({tag, "_done_lvl"}, wif.dig3, 0);
    check_rem({tag, "_done_rem"}, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    wif.start = 1'b0;
    wif.on    = 1'b1;
    #12;
    check("rst_phase", wif.phase, 0);
    check("rst_led", wif.st_light, 8'h00);
    check("rst_done", wif.done, 0);
    check("rst_dig3", wif.dig3, 0);
    check("rst_dig2", wif.dig2, 11);
    check_rem("rst_rem", T);
    #10 rst_n = 1'b1;
    step(2);
    check("idle_hold", wif.phase, 0);

    // Full program with a one-cycle start pulse; DONE must then hold.
    run_program("run1", 1'b0);
    step(3);
    check("done_hold_phase", wif.phase, 5);
    check("done_hold_flag", wif.done, 1);

    // Pause after two FILL cycles; the partial second must survive.
    wif.start = 1'b1;
    step(1);
    wif.start = 1'b0;
    step(2);
    wif.on = 1'b0;
    step(50);
    check("pause_phase", wif.phase, 1);
    check("pause_lvl", wif.dig3, 0);
    check_rem("pause_rem", T);
    wif.on = 1'b1;
    step(1);
    check_rem("resume1_rem", T);
    step(1);
    check_rem("resume2_rem", T - 1);
    check("resume2_lvl", wif.dig3, 1);

    // start while running must not reload the program.
    wif.start = 1'b1;
    step(4);
    wif.start = 1'b0;
    check("run_start_phase", wif.phase, 1);
    check("run_start_lvl", wif.dig3, 2);
    check_rem("run_start_rem", T - 2);

    // Asynchronous reset in the middle of WASH.
    wait_phase("reach_wash", 2);
    step(3);
    rst_n = 1'b0;
    #1;
    check("arst_phase", wif.phase, 0);
    check("arst_lvl", wif.dig3, 0);
    check("arst_led", wif.st_light, 8'h00);
    check_rem("arst_rem", T);
    rst_n = 1'b1;
    step(3);
    check("arst_no_resume", wif.phase, 0);

    // start held high through DONE relaunches after a single DONE cycle.
    run_program("run2", 1'b1);
    measure("relaunch_done", 5, 1);
    check("relaunch_phase", wif.phase, 1);
    check("relaunch_lvl", wif.dig3, 0);
    check_rem("relaunch_rem", T);
    wif.start = 1'b0;

    check("rinse_encoding_seen", seen_rinse, RINSE_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
